pong_referee: RTL and testbench

// Game-flow controller sequencing the ball datapath and scoring. Sits between the frame

---
 rtl/pong_referee.sv | 172 +++++++++++++++++
 tb/tb_pong_referee.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_referee.sv
// Pong game-flow referee: serve hold, per-frame ball stepping, miss detection and scoring.
// Optional feature: define PONG_PAUSE_EN to enable the pause button and the PAUSED state.
module pong_referee #(
   parameter int BALL_SIZE    = 10,
   parameter int MISS_Y_LO    = 30,
   parameter int MISS_Y_HI    = 290,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30,
   parameter int STEP_DIV     = 1,
   parameter int WIN_SCORE    = 7
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       pause,
   input  logic [8:0] ball_y,
   input  logic [7:0] ball_x,
   output logic       ball_reset,
   output logic       ball_step,
   output logic [3:0] score_1,
   output logic [3:0] score_2,
   output logic       serve_to,
   output logic [2:0] game_state,
   output logic [1:0] winner
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SERVE  = 3'd1,
      PLAY   = 3'd2,
      POINT  = 3'd3,
      PAUSED = 3'd4,
      OVER   = 3'd5
   } state_t;

   localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
   localparam logic [7:0] STEP_LAST  = 8'(STEP_DIV - 1);
   localparam logic [3:0] WIN_L      = 4'(WIN_SCORE);

   state_t     state_reg;
   logic [7:0] frame_cnt_reg;
   logic [7:0] div_cnt_reg;
   logic       start_q_reg;
   logic       start_rise;
   logic       pause_rise;
   logic       miss_lo;
   logic       miss_hi;
   logic       unused_ok;

   assign start_rise = start & ~start_q_reg;
   assign game_state = state_reg;

   // High edge is summed one bit wider so a ball near the bottom cannot wrap past the line.
   assign miss_lo = (ball_y <= 9'(MISS_Y_LO));
   assign miss_hi = (({1'b0, ball_y} + 10'(BALL_SIZE)) >= 10'(MISS_Y_HI));

`ifdef PONG_PAUSE_EN
   logic pause_q_reg;
   assign pause_rise = pause & ~pause_q_reg;
   assign unused_ok  = ^ball_x;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) pause_q_reg <= 1'b0;
      else        pause_q_reg <= pause;
   end
`else
   assign pause_rise = 1'b0;
   assign unused_ok  = ^{ball_x, pause};
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         frame_cnt_reg <= 8'd0;
         div_cnt_reg   <= 8'd0;
         start_q_reg   <= 1'b0;
         ball_reset    <= 1'b1;
         ball_step     <= 1'b0;
         score_1       <= 4'd0;
         score_2       <= 4'd0;
         serve_to      <= 1'b0;
         winner        <= 2'b00;
      end else begin
         start_q_reg <= start;
         ball_step   <= 1'b0;
         case (state_reg)
            IDLE, OVER: begin
               if (start_rise) begin
                  state_reg     <= SERVE;
                  score_1       <= 4'd0;
                  score_2       <= 4'd0;
                  winner        <= 2'b00;
                  frame_cnt_reg <= 8'd0;
               end
            end
            SERVE: begin
               if (frame_tick) begin
                  if (frame_cnt_reg == SERVE_LAST) begin
                     state_reg     <= PLAY;
                     frame_cnt_reg <= 8'd0;
                     div_cnt_reg   <= 8'd0;
                     ball_reset    <= 1'b0;
                  end else begin
                     frame_cnt_reg <= frame_cnt_reg + 8'd1;
                  end
               end
            end
            PLAY: begin
               // Misses outrank pause and step; serve goes back toward the side that missed.
               if (miss_lo) begin
                  score_2       <= score_2 + 4'd1;
                  serve_to      <= 1'b0;
                  frame_cnt_reg <= 8'd0;
                  if (score_2 + 4'd1 == WIN_L) begin
                     state_reg  <= OVER;
                     winner     <= 2'b10;
                     ball_reset <= 1'b1;
                  end else begin
                     state_reg <= POINT;
                  end
               end else if (miss_hi) begin
                  score_1       <= score_1 + 4'd1;
                  serve_to      <= 1'b1;
                  frame_cnt_reg <= 8'd0;
                  if (score_1 + 4'd1 == WIN_L) begin
                     state_reg  <= OVER;
                     winner     <= 2'b01;
                     ball_reset <= 1'b1;
                  end else begin
                     state_reg <= POINT;
                  end
               end else if (pause_rise) begin
                  state_reg     <= PAUSED;
                  frame_cnt_reg <= 8'd0;
               end else if (frame_tick) begin
                  if (div_cnt_reg == STEP_LAST) begin
                     ball_step   <= 1'b1;
                     div_cnt_reg <= 8'd0;
                  end else begin
                     div_cnt_reg <= div_cnt_reg + 8'd1;
                  end
               end
            end
            POINT: begin
               if (frame_tick) begin
                  if (frame_cnt_reg == POINT_LAST) begin
                     state_reg     <= SERVE;
                     frame_cnt_reg <= 8'd0;
                     ball_reset    <= 1'b1;
                  end else begin
                     frame_cnt_reg <= frame_cnt_reg + 8'd1;
                  end
               end
            end
            PAUSED: begin
               // Divider is left untouched so stepping resumes mid-count.
               if (pause_rise) begin
                  state_reg     <= PLAY;
                  frame_cnt_reg <= 8'd0;
               end
            end
            default: begin
               state_reg  <= IDLE;
               ball_reset <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pong_referee.sv
// Randomised bench for pong_referee checked every cycle against a rule-level game model.
module tb_pong_referee;

   localparam int BALL_SIZE    = 10;
   localparam int MISS_Y_LO    = 30;
   localparam int MISS_Y_HI    = 290;
   localparam int SERVE_FRAMES = 60;
   localparam int POINT_FRAMES = 30;
   localparam int STEP_DIV     = 2;
   localparam int WIN_SCORE    = 7;
`ifdef PONG_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [8:0] ball_y = 9'd150;
   logic [7:0] ball_x = 8'd0;
   logic       ball_reset, ball_step, serve_to;
   logic [3:0] score_1, score_2;
   logic [2:0] game_state;
   logic [1:0] winner;

   pong_referee #(
      .BALL_SIZE(BALL_SIZE), .MISS_Y_LO(MISS_Y_LO), .MISS_Y_HI(MISS_Y_HI),
      .SERVE_FRAMES(SERVE_FRAMES), .POINT_FRAMES(POINT_FRAMES),
      .STEP_DIV(STEP_DIV), .WIN_SCORE(WIN_SCORE)
   ) dut (
      .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
      .pause(pause), .ball_y(ball_y), .ball_x(ball_x), .ball_reset(ball_reset),
      .ball_step(ball_step), .score_1(score_1), .score_2(score_2),
      .serve_to(serve_to), .game_state(game_state), .winner(winner)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Game model: phase names follow the published debug encoding.
   localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_PAUSED = 4, S_OVER = 5;
   int m_state, m_frames, m_play_ticks, m_s1, m_s2, m_serve, m_win, m_step;
   bit m_prev_start, m_prev_pause;
   bit cur_start = 1'b0;
   bit cur_pause = 1'b0;

   task automatic chk(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_frames = 0; m_play_ticks = 0;
      m_s1 = 0; m_s2 = 0; m_serve = 0; m_win = 0; m_step = 0;
      m_prev_start = 1'b0; m_prev_pause = 1'b0;
   endtask

   task automatic model_step();
      bit sr, pr;
      int y;
      sr = start && !m_prev_start;
      pr = pause && !m_prev_pause;
      m_prev_start = start;
      m_prev_pause = pause;
      m_step = 0;
      y = int'(ball_y);
      case (m_state)
         S_IDLE, S_OVER: if (sr) begin
            m_s1 = 0; m_s2 = 0; m_win = 0; m_frames = 0; m_state = S_SERVE;
         end
         S_SERVE: if (frame_tick) begin
            m_frames++;
            if (m_frames == SERVE_FRAMES) begin
               m_state = S_PLAY; m_frames = 0; m_play_ticks = 0;
            end
         end
         S_PLAY: begin
            if (y <= MISS_Y_LO) begin
               m_s2++; m_serve = 0; m_frames = 0;
               if (m_s2 == WIN_SCORE) begin m_state = S_OVER; m_win = 2; end
               else m_state = S_POINT;
            end else if (y + BALL_SIZE >= MISS_Y_HI) begin
               m_s1++; m_serve = 1; m_frames = 0;
               if (m_s1 == WIN_SCORE) begin m_state = S_OVER; m_win = 1; end
               else m_state = S_POINT;
            end else if (PAUSE_EN && pr) begin
               m_state = S_PAUSED;
            end else if (frame_tick) begin
               m_play_ticks++;
               if (m_play_ticks % STEP_DIV == 0) m_step = 1;
            end
         end
         S_POINT: if (frame_tick) begin
            m_frames++;
            if (m_frames == POINT_FRAMES) begin m_state = S_SERVE; m_frames = 0; end
         end
         S_PAUSED: if (pr) m_state = S_PLAY;
         default: m_state = S_IDLE;
      endcase
   endtask

   // Single compare process, away from the active edge.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("game_state", int'(game_state), m_state);
         chk("ball_reset", int'(ball_reset),
             (m_state == S_IDLE || m_state == S_SERVE || m_state == S_OVER) ? 1 : 0);
         chk("ball_step", int'(ball_step), m_step);
         chk("score_1", int'(score_1), m_s1);
         chk("score_2", int'(score_2), m_s2);
         chk("serve_to", int'(serve_to), m_serve);
         chk("winner", int'(winner), m_win);
      end
   end

   task automatic cycle(input bit s, input bit p, input bit ft, input int y);
      start = s; pause = p; frame_tick = ft; ball_y = 9'(y);
      ball_x = 8'($urandom_range(0, 255));
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic tick_frames(input int n, input int y);
      for (int i = 0; i < n; i++) begin
         cycle(cur_start, cur_pause, 1'b1, y);
         cycle(cur_start, cur_pause, 1'b0, y);
      end
   endtask

   task automatic count_steps(input int frames, output int steps);
      steps = 0;
      for (int i = 0; i < frames; i++) begin
         cycle(cur_start, cur_pause, 1'b1, 150);
         steps += int'(ball_step);
         cycle(cur_start, cur_pause, 1'b0, 150);
         steps += int'(ball_step);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_state"}, int'(game_state), 0);
      chk({tag, "_ball_reset"}, int'(ball_reset), 1);
      chk({tag, "_ball_step"}, int'(ball_step), 0);
      chk({tag, "_scores"}, int'({score_1, score_2}), 0);
      chk({tag, "_serve_winner"}, int'({serve_to, winner}), 0);
   endtask

   initial begin
      int steps;
      int y;
      int miss_vals[6];
      miss_vals = '{30, 0, 17, 280, 290, 511};
      model_reset();
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      check_reset_values("por");
      chk_en = 1'b1;
      repeat (3) cycle(1'b0, 1'b0, 1'b1, 150);

      // Serve: ball_reset drops only after the 60th tick.
      cur_start = 1'b1;
      cycle(cur_start, cur_pause, 1'b0, 150);
      chk("serve_entry", int'(game_state), 1);
      tick_frames(SERVE_FRAMES - 1, 150);
      chk("serve_59_ball_reset", int'(ball_reset), 1);
      cycle(cur_start, cur_pause, 1'b1, 150);
      chk("serve_60_ball_reset", int'(ball_reset), 0);
      chk("serve_60_state", int'(game_state), 2);

      // Divide-by-two stepping: six frames give three single-cycle pulses.
      count_steps(6, steps);
      chk("steps_in_6_frames", steps, 3);

      // Low miss at the exact line.
      cycle(cur_start, cur_pause, 1'b0, 30);
      chk("low_miss_score_2", int'(score_2), 1);
      chk("low_miss_serve_to", int'(serve_to), 0);
      chk("low_miss_state", int'(game_state), 3);
      tick_frames(POINT_FRAMES - 1, 150);
      chk("point_29_state", int'(game_state), 3);
      cycle(cur_start, cur_pause, 1'b1, 150);
      chk("point_30_state", int'(game_state), 1);

      // Player 1 wins seven points through high misses at ball_y=280.
      for (int p = 0; p < WIN_SCORE; p++) begin
         tick_frames(SERVE_FRAMES, 150);
         cycle(cur_start, cur_pause, 1'b0, 280);
         if (p < WIN_SCORE - 1) tick_frames(POINT_FRAMES, 150);
      end
      chk("win_score_1", int'(score_1), 7);
      chk("win_winner", int'(winner), 1);
      chk("win_state", int'(game_state), 5);
      cur_start = 1'b0;
      cycle(cur_start, cur_pause, 1'b0, 150);
      cur_start = 1'b1;
      cycle(cur_start, cur_pause, 1'b0, 150);
      chk("restart_scores", int'({score_1, score_2}), 0);
      chk("restart_state", int'(game_state), 1);

`ifdef PONG_PAUSE_EN
      tick_frames(SERVE_FRAMES, 150);
      cur_pause = 1'b1;
      cycle(cur_start, cur_pause, 1'b0, 150);
      chk("pause_state", int'(game_state), 4);
      count_steps(10, steps);
      chk("paused_steps", steps, 0);
      cur_pause = 1'b0;
      cycle(cur_start, cur_pause, 1'b0, 150);
      cur_pause = 1'b1;
      cycle(cur_start, cur_pause, 1'b0, 150);
      chk("resume_state", int'(game_state), 2);
      count_steps(4, steps);
      chk("resumed_steps", steps, 2);
`endif

      // Random play with boundary-valued misses.
      for (int i = 0; i < 30000; i++) begin
         if ($urandom_range(0, 59) == 0) cur_start = ~cur_start;
         if ($urandom_range(0, 79) == 0) cur_pause = ~cur_pause;
         if (m_state == S_PLAY) begin
            if ($urandom_range(0, 99) == 0) y = miss_vals[$urandom_range(0, 5)];
            else y = int'($urandom_range(MISS_Y_LO + 1, MISS_Y_HI - BALL_SIZE - 1));
         end else begin
            y = int'($urandom_range(0, 511));
         end
         cycle(cur_start, cur_pause, ($urandom_range(0, 3) == 0), y);
      end

      // Reset mid-game: outputs return immediately, without a clock edge.
      chk_en = 1'b0;
      @(posedge clock);
      #3 reset = 1'b0;
      #1 check_reset_values("async");
      model_reset();
      @(posedge clock);
      #1 reset = 1'b1;
      chk_en = 1'b1;
      cur_start = 1'b0;
      repeat (4) cycle(cur_start, cur_pause, 1'b1, 150);
      chk("post_reset_state", int'(game_state), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
